// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN datapath blocks.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } rd_state_t;

  localparam int         RF_DEPTH = 32;
  localparam logic [1:0] STRIDE_1 = 2'd1;
  localparam logic [1:0] STRIDE_2 = 2'd2;

endpackage

// File: rtl/rf_window_reader.sv
// Walks a row-major tile in the register file and streams each 2x2 window
// (TL, TR, BL, BR) downstream over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; read addresses parked at 0
// RUN   | driving window addresses and capturing windows as the slot frees
// LAST  | final window held until accepted, then done
module rf_window_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [3:0]            cfg_width,
  input  logic [3:0]            cfg_height,
  input  logic [1:0]            cfg_stride,
  output logic [ADDR_WIDTH-1:0] rf_add_1,
  output logic [ADDR_WIDTH-1:0] rf_add_2,
  output logic [ADDR_WIDTH-1:0] rf_add_3,
  output logic [ADDR_WIDTH-1:0] rf_add_4,
  input  logic [DATA_WIDTH-1:0] rf_out1,
  input  logic [DATA_WIDTH-1:0] rf_out2,
  input  logic [DATA_WIDTH-1:0] rf_out3,
  input  logic [DATA_WIDTH-1:0] rf_out4,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [DATA_WIDTH-1:0] win_d0,
  output logic [DATA_WIDTH-1:0] win_d1,
  output logic [DATA_WIDTH-1:0] win_d2,
  output logic [DATA_WIDTH-1:0] win_d3,
  output logic                  win_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);
  import cnn_pkg::*;

  rd_state_t             state_q, state_d;
  logic [3:0]            r_q, r_d, c_q, c_d, w_q, w_d, h_q, h_d;
  logic [1:0]            s_q, s_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] add1_q, add1_d, add2_q, add2_d, add3_q, add3_d, add4_q, add4_d;
  logic [DATA_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic                  valid_q, valid_d, last_q, last_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [7:0]            cfg_area;
  logic                  cfg_ok;
  logic                  slot_free;
  logic [4:0]            c_inc, r_inc;
  logic                  row_wrap, final_win, upd_addr;
  logic [ADDR_WIDTH-1:0] tl;

  // Top-left address of window (r,c); the sum wraps naturally at the RF depth.
  function automatic logic [ADDR_WIDTH-1:0] tl_addr(input logic [ADDR_WIDTH-1:0] base,
                                                    input logic [3:0] r, input logic [3:0] c,
                                                    input logic [3:0] w);
    logic [7:0] off;
    off = {4'b0, r} * {4'b0, w} + {4'b0, c};
    return base + ADDR_WIDTH'(off);
  endfunction

  assign cfg_area  = {4'b0, cfg_width} * {4'b0, cfg_height};
  assign cfg_ok    = (cfg_width >= 4'd2) && (cfg_height >= 4'd2) &&
                     (cfg_area <= 8'(RF_DEPTH)) &&
                     ((cfg_stride == STRIDE_1) || (cfg_stride == STRIDE_2));
  assign slot_free = !valid_q || win_ready;
  assign c_inc     = {1'b0, c_q} + {3'b0, s_q};
  assign r_inc     = {1'b0, r_q} + {3'b0, s_q};
  assign row_wrap  = c_inc > ({1'b0, w_q} - 5'd2);
  assign final_win = row_wrap && (r_inc > ({1'b0, h_q} - 5'd2));

  // Next-state: FSM, position counters, address registers and output slot.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    w_d      = w_q;
    h_d      = h_q;
    s_d      = s_q;
    base_d   = base_q;
    add1_d   = add1_q;
    add2_d   = add2_q;
    add3_d   = add3_q;
    add4_d   = add4_q;
    d0_d     = d0_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    d3_d     = d3_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    upd_addr = 1'b0;
    tl       = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            base_d   = cfg_base;
            w_d      = cfg_width;
            h_d      = cfg_height;
            s_d      = cfg_stride;
            r_d      = 4'd0;
            c_d      = 4'd0;
            busy_d   = 1'b1;
            state_d  = RUN;
            upd_addr = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (slot_free) begin
          d0_d    = rf_out1;
          d1_d    = rf_out2;
          d2_d    = rf_out3;
          d3_d    = rf_out4;
          valid_d = 1'b1;
          if (final_win) begin
            last_d  = 1'b1;
            state_d = LAST;
          end else begin
            if (row_wrap) begin
              c_d = 4'd0;
              r_d = r_inc[3:0];
            end else begin
              c_d = c_inc[3:0];
            end
            upd_addr = 1'b1;
          end
        end
      end
      LAST: begin
        if (win_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          r_d     = 4'd0;
          c_d     = 4'd0;
          add1_d  = '0;
          add2_d  = '0;
          add3_d  = '0;
          add4_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Addresses are registered from the next counter values so the read data
    // for the new position is ready at the following capture edge.
    if (upd_addr) begin
      tl     = tl_addr(base_d, r_d, c_d, w_d);
      add1_d = tl;
      add2_d = tl + ADDR_WIDTH'(1);
      add3_d = tl + ADDR_WIDTH'(w_d);
      add4_d = tl + ADDR_WIDTH'(w_d) + ADDR_WIDTH'(1);
    end
  end

  // State registers; reset abandons any partial pass.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      s_q     <= '0;
      base_q  <= '0;
      add1_q  <= '0;
      add2_q  <= '0;
      add3_q  <= '0;
      add4_q  <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      w_q     <= w_d;
      h_q     <= h_d;
      s_q     <= s_d;
      base_q  <= base_d;
      add1_q  <= add1_d;
      add2_q  <= add2_d;
      add3_q  <= add3_d;
      add4_q  <= add4_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rf_add_1  = add1_q;
  assign rf_add_2  = add2_q;
  assign rf_add_3  = add3_q;
  assign rf_add_4  = add4_q;
  assign win_d0    = d0_q;
  assign win_d1    = d1_q;
  assign win_d2    = d2_q;
  assign win_d3    = d3_q;
  assign win_valid = valid_q;
  assign win_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_rf_window_reader.sv
// Directed bench for rf_window_reader with a behavioural register file.
module tb_rf_window_reader;
  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [3:0]    cfg_width = '0;
  logic [3:0]    cfg_height = '0;
  logic [1:0]    cfg_stride = '0;
  logic [AW-1:0] rf_add_1, rf_add_2, rf_add_3, rf_add_4;
  logic [DW-1:0] rf_out1, rf_out2, rf_out3, rf_out4;
  logic          win_valid;
  logic          win_ready = 1'b0;
  logic [DW-1:0] win_d0, win_d1, win_d2, win_d3;
  logic          win_last, busy, done, cfg_err;

  logic [DW-1:0] rf_mem [0:31];
  logic [7:0]    exp_a [0:63][0:3];
  int            exp_n;
  int            checks = 0;
  int            failures = 0;

  assign rf_out1 = rf_mem[rf_add_1];
  assign rf_out2 = rf_mem[rf_add_2];
  assign rf_out3 = rf_mem[rf_add_3];
  assign rf_out4 = rf_mem[rf_add_4];

  always #5 clk = ~clk;

  rf_window_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .nrst(nrst), .start(start),
    .cfg_base(cfg_base), .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride(cfg_stride),
    .rf_add_1(rf_add_1), .rf_add_2(rf_add_2), .rf_add_3(rf_add_3), .rf_add_4(rf_add_4),
    .rf_out1(rf_out1), .rf_out2(rf_out2), .rf_out3(rf_out3), .rf_out4(rf_out4),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_d0(win_d0), .win_d1(win_d1), .win_d2(win_d2), .win_d3(win_d3),
    .win_last(win_last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  function automatic logic [56:0] all_outs();
    return {rf_add_1, rf_add_2, rf_add_3, rf_add_4, win_d0, win_d1, win_d2, win_d3,
            win_valid, win_last, busy, done, cfg_err};
  endfunction

  // Reference window list: row-major walk, addresses modulo 32.
  task automatic build_exp(input int base, input int w, input int h, input int s);
    int tl;
    exp_n = 0;
    for (int r = 0; r <= h - 2; r += s) begin
      for (int c = 0; c <= w - 2; c += s) begin
        tl = (base + r * w + c) % 32;
        exp_a[exp_n][0] = 8'(tl);
        exp_a[exp_n][1] = 8'((tl + 1) % 32);
        exp_a[exp_n][2] = 8'((tl + w) % 32);
        exp_a[exp_n][3] = 8'((tl + w + 1) % 32);
        exp_n++;
      end
    end
  endtask

  task automatic start_pass(input int base, input int w, input int h, input int s);
    build_exp(base, w, h, s);
    @(posedge clk); #1;
    cfg_base = AW'(base); cfg_width = 4'(w); cfg_height = 4'(h); cfg_stride = 2'(s);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, win_valid, cfg_err, rf_add_1, rf_add_2, rf_add_3, rf_add_4} !==
        {1'b1, 1'b0, 1'b0, exp_a[0][0][4:0], exp_a[0][1][4:0], exp_a[0][2][4:0], exp_a[0][3][4:0]}) begin
      failures++;
      $display("FAIL start_accept: busy=%b valid=%b err=%b addr=%0d,%0d,%0d,%0d expected busy=1 valid=0 err=0 addr=%0d,%0d,%0d,%0d",
               busy, win_valid, cfg_err, rf_add_1, rf_add_2, rf_add_3, rf_add_4,
               exp_a[0][0], exp_a[0][1], exp_a[0][2], exp_a[0][3]);
    end
  endtask

  // Drives win_ready, checks every handshaked window against the reference list,
  // stall stability, and the done pulse. Returns early after stop_after handshakes.
  task automatic collect(input bit rand_ready, input int stop_after, input int busy_start_at,
                         input bit check_timing, output int got);
    int hs, last_cyc;
    bit stall, finished, expect_done;
    logic [DW-1:0] s0, s1, s2, s3;
    logic sl;
    hs = 0; last_cyc = -1; stall = 0; finished = 0; expect_done = 0;
    s0 = '0; s1 = '0; s2 = '0; s3 = '0; sl = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      if (stop_after >= 0 && hs == stop_after) break;
      if (cyc == busy_start_at) begin
        cfg_base = 5'd20; cfg_width = 4'd2; cfg_height = 4'd2; cfg_stride = 2'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      win_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b0) begin
        failures++;
        $display("FAIL stray_cfg_err: cfg_err=%b expected 0 at cycle %0d", cfg_err, cyc);
      end
      if (expect_done) begin
        checks++;
        if ({done, busy, win_valid} !== 3'b100) begin
          failures++;
          $display("FAIL done_pulse: done/busy/valid=%b expected 100", {done, busy, win_valid});
        end
        finished = 1;
        break;
      end
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL early_done: done=%b expected 0 at cycle %0d", done, cyc);
      end
      if (stall) begin
        checks++;
        if ({win_valid, win_last, win_d0, win_d1, win_d2, win_d3} !== {1'b1, sl, s0, s1, s2, s3}) begin
          failures++;
          $display("FAIL stall_hold: valid=%b last=%b d=%0d,%0d,%0d,%0d expected valid=1 last=%b d=%0d,%0d,%0d,%0d",
                   win_valid, win_last, win_d0, win_d1, win_d2, win_d3, sl, s0, s1, s2, s3);
        end
      end
      if (win_valid && win_ready) begin
        checks++;
        if (hs >= exp_n) begin
          failures++;
          $display("FAIL extra_window: window %0d seen, expected only %0d", hs, exp_n);
        end else if ({win_d0, win_d1, win_d2, win_d3, win_last} !==
                     {exp_a[hs][0], exp_a[hs][1], exp_a[hs][2], exp_a[hs][3], (hs == exp_n - 1)}) begin
          failures++;
          $display("FAIL window_%0d: got %0d,%0d,%0d,%0d last=%b expected %0d,%0d,%0d,%0d last=%b",
                   hs, win_d0, win_d1, win_d2, win_d3, win_last,
                   exp_a[hs][0], exp_a[hs][1], exp_a[hs][2], exp_a[hs][3], (hs == exp_n - 1));
        end
        if (check_timing && hs == 0) begin
          checks++;
          if (cyc != 1) begin
            failures++;
            $display("FAIL first_latency: first window at cycle %0d expected 1", cyc);
          end
        end
        hs++;
        if (hs == exp_n) begin
          expect_done = 1;
          last_cyc = cyc;
        end
      end
      stall = win_valid && !win_ready;
      s0 = win_d0; s1 = win_d1; s2 = win_d2; s3 = win_d3; sl = win_last;
    end
    start = 1'b0;
    got = hs;
    if (stop_after < 0) begin
      checks++;
      if (!finished) begin
        failures++;
        $display("FAIL pass_timeout: got %0d windows expected %0d with done", hs, exp_n);
      end
    end
    if (check_timing) begin
      checks++;
      if (last_cyc != exp_n) begin
        failures++;
        $display("FAIL throughput: last window at cycle %0d expected %0d", last_cyc, exp_n);
      end
    end
  endtask

  task automatic test_reset();
    #1 nrst = 1'b0;
    #2;
    checks++;
    if (all_outs() !== 57'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    @(negedge clk); @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs() !== 57'd0) begin
      failures++;
      $display("FAIL idle_outputs: got %h expected 0", all_outs());
    end
  endtask

  task automatic test_stride1();
    int got;
    start_pass(0, 4, 4, 1);
    collect(1'b0, -1, -1, 1'b1, got);
    checks++;
    if (got != 9) begin
      failures++;
      $display("FAIL s1_count: got %0d expected 9", got);
    end
  endtask

  task automatic test_stride2();
    int got;
    start_pass(0, 4, 4, 2);
    collect(1'b0, -1, -1, 1'b1, got);
    checks++;
    if (got != 4) begin
      failures++;
      $display("FAIL s2_count: got %0d expected 4", got);
    end
  endtask

  task automatic test_wrap();
    int got;
    start_pass(30, 2, 2, 1);
    collect(1'b0, -1, -1, 1'b1, got);
    checks++;
    if (got != 1) begin
      failures++;
      $display("FAIL wrap_count: got %0d expected 1", got);
    end
  endtask

  task automatic test_backpressure();
    int got;
    start_pass(0, 4, 4, 1);
    collect(1'b1, -1, -1, 1'b0, got);
    checks++;
    if (got != 9) begin
      failures++;
      $display("FAIL bp_count: got %0d expected 9", got);
    end
    win_ready = 1'b1;
  endtask

  task automatic test_cfg_err();
    int ws [3] = '{8, 1, 4};
    int hs [3] = '{8, 4, 4};
    int ss [3] = '{1, 1, 3};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cfg_base = 5'd0; cfg_width = 4'(ws[i]); cfg_height = 4'(hs[i]); cfg_stride = 2'(ss[i]);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if ({cfg_err, busy, win_valid} !== 3'b100) begin
        failures++;
        $display("FAIL cfg_err_%0d: err/busy/valid=%b expected 100", i, {cfg_err, busy, win_valid});
      end
      @(negedge clk);
      checks++;
      if ({cfg_err, busy, win_valid} !== 3'b000) begin
        failures++;
        $display("FAIL cfg_err_clear_%0d: err/busy/valid=%b expected 000", i, {cfg_err, busy, win_valid});
      end
    end
  endtask

  task automatic test_start_while_busy();
    int got;
    start_pass(0, 4, 4, 1);
    collect(1'b0, -1, 2, 1'b0, got);
    checks++;
    if (got != 9) begin
      failures++;
      $display("FAIL busy_start_count: got %0d expected 9", got);
    end
  endtask

  task automatic test_midpass_reset();
    int got;
    start_pass(0, 4, 4, 1);
    collect(1'b0, 3, -1, 1'b0, got);
    checks++;
    if (got != 3) begin
      failures++;
      $display("FAIL pre_reset_count: got %0d expected 3", got);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 57'd0) begin
      failures++;
      $display("FAIL midpass_reset: got %h expected 0", all_outs());
    end
    @(negedge clk); @(negedge clk);
    nrst = 1'b1;
    start_pass(0, 4, 4, 1);
    collect(1'b0, -1, -1, 1'b1, got);
    checks++;
    if (got != 9) begin
      failures++;
      $display("FAIL replay_count: got %0d expected 9", got);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 8'(i);
    test_reset();
    test_stride1();
    test_stride2();
    test_wrap();
    test_backpressure();
    test_cfg_err();
    test_start_while_busy();
    test_midpass_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
